multdiv_sign_restore: RTL and testbench
=======================================

Name: multdiv_sign_restore

Overview:
- Output-side sign stage for the signed multdiv unit. The operand side feeds the unsigned multiply/divide core with magnitudes.
- This block latches the operand signs at operation start and waits for the core's unsigned result.
- It then re-applies the correct two's-complement sign, detects overflow and divide-by-zero, and presents data_result with a one-cycle data_resultRDY pulse.

Parameters:
- WIDTH, 32, operand/result width; core magnitude is 2*WIDTH bits. Only 32 is required to be verified.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- ctrl_MULT  input  1  one-cycle start pulse, signed multiply
- ctrl_DIV  input  1  one-cycle start pulse, signed divide
- data_operandA  input  WIDTH  operand A, sampled only on a start cycle
- data_operandB  input  WIDTH  operand B, sampled only on a start cycle
- core_done  input  1  one-cycle pulse: core_mag valid
- core_mag  input  2*WIDTH  unsigned core result; product magnitude, or quotient magnitude in [WIDTH-1:0]
- data_result  output  WIDTH  signed result, held until next start
- data_exception  output  1  overflow / divide-by-zero flag, valid with data_resultRDY, held like data_result
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high from the cycle after a start until data_resultRDY

Behaviour:
- Reset (async): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; latched signs and flags cleared.
- States: IDLE, WAIT, FIX, DONE.
- Start (any state):
  - ctrl_MULT|ctrl_DIV at an edge latches the following, then goes to WAIT:
    - op (MULT wins if both asserted)
    - sA = A[WIDTH-1]
    - sB = B[WIDTH-1]
    - neg = sA^sB
    - bz = (B==0)
  - A start while busy aborts the current operation. The pending result is discarded and no RDY pulse is issued for it.
- WAIT:
  - If op=DIV and bz: next edge goes to DONE with data_result=0 and data_exception=1. core_done is ignored.
  - Otherwise, on the edge sampling core_done=1: register core_mag and go to FIX.
- FIX: compute r = neg ? (~mag + 1) : mag over 2*WIDTH bits.
  - MULT: data_result = r[WIDTH-1:0]; exception = r[2W-1:W] is not all copies of r[WIDTH-1], or (mag≠0 and r[2W-1] ≠ neg).
  - DIV: data_result = r[WIDTH-1:0]; exception = (mag[2W-1:W] ≠ 0) or (!neg and mag[WIDTH-1]). This covers -2^31 / -1 giving magnitude 0x80000000.
  - Go to DONE.
- DONE: data_resultRDY=1 for exactly this cycle, busy=0, then IDLE.
- Latency: core_done high in cycle N → data_resultRDY high in cycle N+2. Divide-by-zero: start at cycle S → data_resultRDY high in cycle S+2.
- data_result and data_exception update only on the FIX→DONE edge (or the bz path) and hold through IDLE until the next start. At the next start, data_exception clears to 0.
- core_done in IDLE, FIX or DONE is ignored.
- A zero product or quotient with neg=1 yields 0, not an exception.
- The remainder is not produced by this block.

Decomposition:
- Shared multdiv package: state encodings (IDLE/WAIT/FIX/DONE) and an OP_MULT/OP_DIV constant. WIDTH comes from the package default.
- Sub-module sign_apply: combinational conditional two's-complement negate of a 2*WIDTH vector (out = en ? -in : in), using the team's cla adder with A=0, B=~in, Cin=1 when enabled. It is instantiated once in FIX.

Test Plan:
- MULT A=-3 (0xFFFFFFFD), B=7; core_mag=21 → data_result=0xFFFFFFEB (-21), exception=0, RDY exactly 2 cycles after core_done.
- DIV A=-100, B=-7; core_mag=14 → data_result=14, exception=0. Then DIV A=100, B=-7, core_mag=14 → 0xFFFFFFF2.
- DIV A=5, B=0 → RDY at start+2, data_result=0, exception=1; a core_done pulse arriving later produces no second RDY.
- DIV A=0x80000000, B=-1; core_mag=0x80000000 → exception=1. MULT 0x10000 × 0x10000, core_mag=0x1_0000_0000 → exception=1, data_result=0.
- MULT -65536 × 32768, core_mag=0x80000000 → data_result=0x80000000, exception=0 (exact minimum fits).
- Restart mid-WAIT with a new MULT 2×3: no RDY for the aborted op; core_mag=6 → data_result=6. Reset asserted in FIX → all outputs 0 immediately, no RDY.

Source files
------------

// File: rtl/multdiv_sign_restore_pkg.sv
// Shared definitions for the signed multdiv output sign stage.
//   MD_WIDTH   : default operand/result width
//   md_state_e : sign stage sequencing states
//   OP_MULT/OP_DIV : latched operation code
package multdiv_sign_restore_pkg;
    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;
endpackage

// File: rtl/multdiv_sign_restore_sign_apply.sv
// Conditional two's-complement negate: out_vec = en ? -in_vec : in_vec.
// Built as a generate/propagate adder with A=0, B=in_vec^{en}, Cin=en, so
// the same adder passes the value through unchanged when en is low.
//   en      : negate enable
//   in_vec  : W-bit input
//   out_vec : W-bit result
module multdiv_sign_restore_sign_apply #(
    parameter int W = 64
) (
    input  logic         en,
    input  logic [W-1:0] in_vec,
    output logic [W-1:0] out_vec
);
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   carry;

    always_comb begin
        opa      = '0;
        opb      = in_vec ^ {W{en}};
        gen      = opa & opb;
        prop     = opa ^ opb;
        carry    = '0;
        carry[0] = en;
        out_vec  = '0;
        for (int i = 0; i < W; i++) begin
            out_vec[i]   = prop[i] ^ carry[i];
            carry[i+1]   = gen[i] | (prop[i] & carry[i]);
        end
    end
endmodule

// File: rtl/multdiv_sign_restore.sv
// Output-side sign stage of the signed multdiv unit. Latches operand signs
// at start, waits for the unsigned core result, re-applies the sign and
// flags overflow / divide-by-zero.
//   clock, reset            : clock, async active-high reset
//   ctrl_MULT, ctrl_DIV     : one-cycle start pulses (MULT wins if both)
//   data_operandA/B         : operands, sampled on a start cycle only
//   core_done, core_mag     : unsigned core result strobe and magnitude
//   data_result             : signed result, held until next completion
//   data_exception          : overflow / divide-by-zero, cleared on start
//   data_resultRDY          : one-cycle completion pulse
//   busy                    : operation in flight
module multdiv_sign_restore
    import multdiv_sign_restore_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_MULT,
    input  logic               ctrl_DIV,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic               core_done,
    input  logic [2*WIDTH-1:0] core_mag,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_exception,
    output logic               data_resultRDY,
    output logic               busy
);
    localparam int W2 = 2 * WIDTH;

    md_state_e        state_q, state_d;
    logic             op_q, op_d;
    logic             neg_q, neg_d;
    logic             bz_q, bz_d;
    logic [W2-1:0]    mag_q, mag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [W2-1:0]    signed_mag;
    logic             mult_exc;
    logic             div_exc;

    // Only the sign bit of A matters here; magnitudes go to the core.
    logic unused_operand_a_bits;
    assign unused_operand_a_bits = ^data_operandA[WIDTH-2:0];

    multdiv_sign_restore_sign_apply #(.W(W2)) u_sign_apply (
        .en      (neg_q),
        .in_vec  (mag_q),
        .out_vec (signed_mag)
    );

    // Product must sign-extend cleanly from bit WIDTH-1, and a nonzero
    // magnitude must land with the expected sign.
    assign mult_exc = (signed_mag[W2-1:WIDTH] != {WIDTH{signed_mag[WIDTH-1]}}) ||
                      ((mag_q != '0) && (signed_mag[W2-1] != neg_q));
    // A positive quotient of 2^(WIDTH-1) (min / -1) does not fit.
    assign div_exc  = (mag_q[W2-1:WIDTH] != '0) || (!neg_q && mag_q[WIDTH-1]);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        bz_d     = bz_q;
        mag_d    = mag_q;
        result_d = result_q;
        exc_d    = exc_q;
        unique case (state_q)
            ST_WAIT: begin
                if (op_q == OP_DIV && bz_q) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                    state_d  = ST_DONE;
                end else if (core_done) begin
                    mag_d   = core_mag;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = signed_mag[WIDTH-1:0];
                exc_d    = (op_q == OP_MULT) ? mult_exc : div_exc;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A start overrides everything, aborting any operation in flight.
        if (ctrl_MULT || ctrl_DIV) begin
            op_d     = ctrl_MULT ? OP_MULT : OP_DIV;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            bz_d     = (data_operandB == '0);
            exc_d    = 1'b0;
            result_d = result_q;
            state_d  = ST_WAIT;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MULT;
            neg_q    <= 1'b0;
            bz_q     <= 1'b0;
            mag_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            bz_q     <= bz_d;
            mag_q    <= mag_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == ST_DONE);
    assign busy           = (state_q == ST_WAIT) || (state_q == ST_FIX);
endmodule

// File: tb/tb_multdiv_sign_restore.sv
module tb_multdiv_sign_restore;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        core_done = 1'b0;
    logic [63:0] core_mag = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int passed = 0;
    int total  = 0;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    multdiv_sign_restore dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .core_done      (core_done),
        .core_mag       (core_mag),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Reference: exact signed arithmetic; core magnitude is |exact result|.
    function automatic void model(input bit op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] mag, output logic [31:0] res, output bit exc);
        longint sa, sb, v;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (op && b == 32'd0) begin
            mag = '0; res = '0; exc = 1'b1;
            return;
        end
        v   = op ? (sa / sb) : (sa * sb);
        mag = (v < 0) ? 64'(-v) : 64'(v);
        res = v[31:0];
        exc = (v > MAXI) || (v < MINI);
    endfunction

    // Drives one full operation (acting as the core) and checks its completion.
    task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                          input int dly, input string name);
        logic [63:0] m;
        logic [31:0] er;
        bit          ee;
        int          cnt;
        model(op, a, b, m, er, ee);
        @(negedge clock);
        ctrl_MULT = ~op; ctrl_DIV = op; data_operandA = a; data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 0; ctrl_DIV = 0;
        data_operandA = $urandom; data_operandB = $urandom;
        total++;
        if (busy !== 1'b1) $display("FAIL %s busy after start: got %b want 1", name, busy);
        else passed++;
        if (!(op && b == 32'd0)) begin
            repeat (dly) @(negedge clock);
            core_done = 1; core_mag = m;
            @(negedge clock);
            core_done = 0; core_mag = {$urandom, $urandom};
        end
        cnt = 1;
        while (!data_resultRDY && cnt < 10) begin
            @(negedge clock);
            cnt++;
        end
        total++;
        if (cnt !== 2) $display("FAIL %s latency: got %0d want 2", name, cnt);
        else passed++;
        total++;
        if (data_result !== er) $display("FAIL %s result: got %h want %h", name, data_result, er);
        else passed++;
        total++;
        if (data_exception !== ee) $display("FAIL %s exception: got %b want %b", name, data_exception, ee);
        else passed++;
        @(negedge clock);
        total++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== er)
            $display("FAIL %s after-rdy: rdy=%b busy=%b res=%h want rdy=0 busy=0 res=%h",
                     name, data_resultRDY, busy, data_result, er);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset state: res=%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        else passed++;
        reset = 0;
        @(negedge clock);
    endtask

    task automatic test_mult_basic();
        run_op(0, 32'hFFFFFFFD, 32'd7, 1, "mult_neg3x7");
    endtask

    task automatic test_div_basic();
        run_op(1, -32'sd100, -32'sd7, 2, "div_m100_m7");
        run_op(1, 32'd100, -32'sd7, 0, "div_100_m7");
    endtask

    task automatic test_div_by_zero();
        run_op(1, 32'd5, 32'd0, 0, "div_by_zero");
        core_done = 1; core_mag = 64'd1;
        @(negedge clock);
        core_done = 0;
        begin
            bit seen = 0;
            for (int i = 0; i < 5; i++) begin
                if (data_resultRDY) seen = 1;
                @(negedge clock);
            end
            total++;
            if (seen !== 1'b0 || data_result !== 32'd0 || data_exception !== 1'b1)
                $display("FAIL dbz late core_done: rdy_seen=%b res=%h exc=%b want 0/0/1",
                         seen, data_result, data_exception);
            else passed++;
        end
        // Next start clears the exception but keeps the held result.
        ctrl_MULT = 1; data_operandA = 32'd1; data_operandB = 32'd1;
        @(negedge clock);
        ctrl_MULT = 0;
        total++;
        if (data_exception !== 1'b0 || data_result !== 32'd0)
            $display("FAIL exc clear on start: exc=%b res=%h want 0/0", data_exception, data_result);
        else passed++;
        core_done = 1; core_mag = 64'd1;
        @(negedge clock);
        core_done = 0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_overflow();
        run_op(1, 32'h80000000, 32'hFFFFFFFF, 1, "div_min_m1");
        run_op(0, 32'h00010000, 32'h00010000, 3, "mult_2p32");
        run_op(0, -32'sd65536, 32'd32768, 0, "mult_min_fits");
        run_op(0, 32'd0, -32'sd9, 1, "mult_zero_neg");
        run_op(1, 32'd3, -32'sd7, 1, "div_zero_neg");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit          op;
            logic [31:0] a, b;
            op = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom; b = $urandom;
            end else begin
                a = 32'($signed($urandom_range(0, 2000)) - 1000);
                b = 32'($signed($urandom_range(0, 60)) - 30);
            end
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            run_op(op, a, b, $urandom_range(0, 4), "random");
        end
    endtask

    task automatic test_restart();
        int rdy_cnt = 0;
        int cyc = 0;
        @(negedge clock);
        ctrl_MULT = 1; data_operandA = 32'd7; data_operandB = 32'd9;
        @(negedge clock);
        ctrl_MULT = 0;
        if (data_resultRDY) rdy_cnt++;
        @(negedge clock);
        ctrl_MULT = 1; data_operandA = 32'd2; data_operandB = 32'd3;
        if (data_resultRDY) rdy_cnt++;
        @(negedge clock);
        ctrl_MULT = 0;
        if (data_resultRDY) rdy_cnt++;
        core_done = 1; core_mag = 64'd6;
        @(negedge clock);
        core_done = 0;
        while (!data_resultRDY && cyc < 10) begin
            @(negedge clock);
            cyc++;
        end
        if (data_resultRDY) rdy_cnt++;
        total++;
        if (data_result !== 32'd6 || data_exception !== 1'b0)
            $display("FAIL restart result: res=%h exc=%b want 00000006/0", data_result, data_exception);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        total++;
        if (rdy_cnt !== 1) $display("FAIL restart rdy pulses: got %0d want 1", rdy_cnt);
        else passed++;
    endtask

    task automatic test_reset_in_fix();
        bit seen = 0;
        @(negedge clock);
        ctrl_MULT = 1; data_operandA = 32'hFFFFFFFD; data_operandB = 32'd7;
        @(negedge clock);
        ctrl_MULT = 0;
        core_done = 1; core_mag = 64'd21;
        @(negedge clock);
        core_done = 0;
        reset = 1;
        #1;
        total++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset in fix: res=%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_exception, data_resultRDY, busy);
        else passed++;
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            if (data_resultRDY) seen = 1;
            @(negedge clock);
        end
        total++;
        if (seen !== 1'b0 || data_result !== 32'd0)
            $display("FAIL post-reset quiet: rdy_seen=%b res=%h want 0/0", seen, data_result);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_basic();
        test_div_by_zero();
        test_overflow();
        test_random();
        test_restart();
        test_reset_in_fix();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
